instruction_encoder: RTL

- Write-side counterpart of instructionSetter. instructionSetter delivers a 32-bit instruction and its sign-extended 64-bit immediate; this block takes decoded RV64I fields plus a signed 64-bit immediate and re-encodes them into a 32-bit instruction word.
- Emits each word with a sequential word address, for loading instruction memory or feeding test programs.
- Single registered output stage with valid/ready handshakes on both sides; range-checks immediates and counts errors.

---
 rtl/instruction_encoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder: re-encodes decoded RV64I fields plus a signed 64-bit
// immediate into a 32-bit instruction word. One registered output stage with
// valid/ready on both sides; each emitted word carries a sequential word
// address. Out-of-range immediates or illegal formats emit a NOP with error=1.
module instruction_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [63:0]       immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] addr,
  output logic              error,
  output logic [7:0]        err_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [2:0]        FMT_R = 3'd0;
  localparam logic [2:0]        FMT_I = 3'd1;
  localparam logic [2:0]        FMT_S = 3'd2;
  localparam logic [2:0]        FMT_B = 3'd3;
  localparam logic [2:0]        FMT_U = 3'd4;
  localparam logic [2:0]        FMT_J = 3'd5;
  localparam logic [31:0]       NOP   = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t             state_q, state_d;
  logic               accept;
  logic [ADDR_W-1:0]  next_addr;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic signed [63:0] imm;

  assign imm       = immediate;
  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == FULL);

  // Encode the current input fields and flag range/format errors.
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        enc_err  = (imm < -64'sd2048) || (imm > 64'sd2047);
        enc_word = {immediate[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        enc_err  = (imm < -64'sd2048) || (imm > 64'sd2047);
        enc_word = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
      end
      FMT_B: begin
        enc_err  = (imm < -64'sd4096) || (imm > 64'sd4094) || immediate[0];
        enc_word = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                    immediate[4:1], immediate[11], opcode};
      end
      FMT_U: begin
        enc_err  = (immediate[11:0] != 12'd0) ||
                   (imm < -64'sd2147483648) || (imm > 64'sd2147479552);
        enc_word = {immediate[31:12], rd, opcode};
      end
      FMT_J: begin
        enc_err  = (imm < -64'sd1048576) || (imm > 64'sd1048574) || immediate[0];
        enc_word = {immediate[20], immediate[10:1], immediate[11],
                    immediate[19:12], rd, opcode};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = NOP;
  end

  // Next-state logic for the single output slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Output word, address counter and error counter; only accepted words update them.
  // NOTE: every datapath flop here is reset, so a word held at reset is dropped rather than re-emitted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction <= 32'd0;
      addr        <= BASE;
      error       <= 1'b0;
      err_count   <= 8'd0;
      next_addr   <= BASE;
    end else if (accept) begin
      instruction <= enc_word;
      addr        <= next_addr;
      next_addr   <= next_addr + ADDR_W'(1);
      error       <= enc_err;
      if (enc_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule
